// File: rtl/biquad_rr_scheduler.sv
// rtl/biquad_rr_scheduler.sv - round-robin channel scheduler for one shared pipelined biquad engine.
// Optional per-channel issue and stall counters enabled by `define BIQ_SCHED_STATS_EN.
module biquad_rr_scheduler #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int LAT    = 2,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_CH-1:0]          ch_valid,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic [NUM_CH-1:0]          ch_ready,
    output logic                       eng_valid,
    output logic signed [DATA_W-1:0]   eng_din,
    output logic [CH_W-1:0]            eng_ch,
    output logic                       eng_clr,
    input  logic signed [DATA_W-1:0]   eng_dout,
    output logic                       out_valid,
    output logic signed [DATA_W-1:0]   out_data,
    output logic [CH_W-1:0]            out_ch,
    output logic                       idle
`ifdef BIQ_SCHED_STATS_EN
    ,
    input  logic                       stat_clr,
    output logic [NUM_CH*16-1:0]       stat_issue,
    output logic [15:0]                stall_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                r_state;
    logic [CH_W-1:0]       r_rr_ptr;
    logic [3:0]            r_cool [NUM_CH];
    logic [LAT:1]          r_tag_v;
    logic [CH_W-1:0]       r_tag_ch [LAT:1];

    logic [NUM_CH-1:0]     w_elig;
    logic                  w_gnt_any;
    logic [CH_W-1:0]       w_gnt_idx;
    logic signed [DATA_W-1:0] w_sample;
    logic                  w_grant_en;
    logic                  w_empty;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_elig[i] = ch_valid[i] && (r_cool[i] == 4'd0);
        end
    end

    // Scan upward from r_rr_ptr with wrap; first eligible channel wins.
    always_comb begin
        int              v_idx;
        logic [CH_W-1:0] v_sel;
        v_idx     = 0;
        v_sel     = '0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_sample  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_CH) v_idx = v_idx - NUM_CH;
            v_sel = CH_W'(v_idx);
            if (!w_gnt_any && w_elig[v_sel]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = v_sel;
                w_sample  = ch_data[v_idx*DATA_W +: DATA_W];
            end
        end
    end

    assign w_grant_en = (r_state == S_RUN) && en && w_gnt_any;
    assign ch_ready   = w_grant_en ? (NUM_CH'(1) << w_gnt_idx) : '0;
    assign w_empty    = !eng_valid && !(|r_tag_v) && !out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_tag_v   <= '0;
            for (int k = 1; k <= LAT; k++) r_tag_ch[k] <= '0;
            eng_valid <= 1'b0;
            eng_din   <= '0;
            eng_ch    <= '0;
            eng_clr   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            idle      <= 1'b1;
        end else begin
            eng_clr   <= 1'b0;
            eng_valid <= w_grant_en;
            if (w_grant_en) begin
                eng_din  <= w_sample;
                eng_ch   <= w_gnt_idx;
                r_rr_ptr <= (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + CH_W'(1);
            end
            // Tag pipe stage k holds the tag issued k cycles ago, lined up with the engine.
            r_tag_v[1]  <= eng_valid;
            r_tag_ch[1] <= eng_ch;
            for (int k = 2; k <= LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_ch[k] <= r_tag_ch[k-1];
            end
            out_valid <= r_tag_v[LAT];
            if (r_tag_v[LAT]) begin
                out_data <= eng_dout;
                out_ch   <= r_tag_ch[LAT];
            end
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_RUN;
                        eng_clr <= 1'b1;
                        idle    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!en) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (en) begin
                        r_state <= S_RUN;
                    end else if (w_empty) begin
                        r_state <= S_IDLE;
                        idle    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    idle    <= 1'b1;
                end
            endcase
        end
    end

    // A granted channel sleeps LAT cycles so its y[n] is back before x[n+1] issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) r_cool[i] <= 4'd0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_grant_en && (w_gnt_idx == CH_W'(i))) begin
                    r_cool[i] <= 4'(LAT);
                end else if (r_cool[i] != 4'd0) begin
                    r_cool[i] <= r_cool[i] - 4'd1;
                end
            end
        end
    end

`ifdef BIQ_SCHED_STATS_EN
    logic [15:0] r_stat [NUM_CH];
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall   = (r_state == S_RUN) && (|ch_valid) && !w_grant_en;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) r_stat[i] <= '0;
            r_stall_cnt <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_CH; i++) r_stat[i] <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_grant_en && (w_gnt_idx == CH_W'(i)) && (r_stat[i] != 16'hFFFF)) begin
                    r_stat[i] <= r_stat[i] + 16'd1;
                end
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) stat_issue[i*16 +: 16] = r_stat[i];
    end
`endif

endmodule

// File: tb/tb_biquad_rr_scheduler.sv
// tb/tb_biquad_rr_scheduler.sv - directed self-checking bench for biquad_rr_scheduler (NUM_CH=4, LAT=2).
module tb_biquad_rr_scheduler;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  ch_valid;
    logic [63:0] ch_data;
    logic [3:0]  ch_ready;
    logic        eng_valid;
    logic [15:0] eng_din;
    logic [1:0]  eng_ch;
    logic        eng_clr;
    logic [15:0] eng_dout;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_ch;
    logic        idle;

    int checks;
    int errors;

    logic [15:0] dv [4];
    logic [15:0] m_p0, m_p1;

    biquad_rr_scheduler #(.NUM_CH(4), .DATA_W(16), .LAT(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
        .eng_valid(eng_valid), .eng_din(eng_din), .eng_ch(eng_ch), .eng_clr(eng_clr),
        .eng_dout(eng_dout),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine stand-in: result = x + 7*ch, two cycles after issue.
    always @(posedge clk) begin
        m_p0 <= eng_din + 16'(7 * int'(eng_ch));
        m_p1 <= m_p0;
    end
    assign eng_dout = m_p1;

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; ch_valid = 4'h0;
        ch_data = {dv[3], dv[2], dv[1], dv[0]};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; ch_valid = 4'hF;
        ch_data = {dv[3], dv[2], dv[1], dv[0]};
        repeat (2) @(negedge clk);
        checks++;
        if ({ch_ready, eng_valid, eng_din, eng_ch, eng_clr} !== 24'd0) begin
            errors++;
            $display("FAIL reset_issue got rdy=%b ev=%b din=%h ch=%0d clr=%b exp all 0",
                     ch_ready, eng_valid, eng_din, eng_ch, eng_clr);
        end
        checks++;
        if ({out_valid, out_data, out_ch} !== 19'd0) begin
            errors++;
            $display("FAIL reset_out got ov=%b od=%h oc=%0d exp all 0", out_valid, out_data, out_ch);
        end
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
        rst = 1'b0; en = 1'b1; ch_valid = 4'h0;
        @(negedge clk);
        checks++;
        if (eng_clr !== 1'b1) begin errors++; $display("FAIL clr_pulse got %b exp 1", eng_clr); end
        checks++;
        if (idle !== 1'b0) begin errors++; $display("FAIL run_idle got %b exp 0", idle); end
        @(negedge clk);
        checks++;
        if (eng_clr !== 1'b0) begin errors++; $display("FAIL clr_width got %b exp 0", eng_clr); end
    endtask

    task automatic test_rotation();
        do_reset();
        en = 1'b1; ch_valid = 4'hF;
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (ch_ready !== (4'b0001 << (k % 4))) begin
                errors++;
                $display("FAIL rot_ready k=%0d got %b exp %b", k, ch_ready, 4'b0001 << (k % 4));
            end
            if (k >= 1) begin
                checks++;
                if (eng_valid !== 1'b1 || eng_ch !== 2'((k - 1) % 4) || eng_din !== dv[(k - 1) % 4]) begin
                    errors++;
                    $display("FAIL rot_issue k=%0d got ev=%b ch=%0d din=%0d exp 1 %0d %0d",
                             k, eng_valid, eng_ch, eng_din, (k - 1) % 4, dv[(k - 1) % 4]);
                end
            end
            checks++;
            if (k >= 4) begin
                if (out_valid !== 1'b1 || out_ch !== 2'((k - 4) % 4) ||
                    out_data !== dv[(k - 4) % 4] + 16'(7 * ((k - 4) % 4))) begin
                    errors++;
                    $display("FAIL rot_out k=%0d got ov=%b ch=%0d d=%0d exp 1 %0d %0d", k, out_valid,
                             out_ch, out_data, (k - 4) % 4, dv[(k - 4) % 4] + 16'(7 * ((k - 4) % 4)));
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rot_early_out k=%0d got %b exp 0", k, out_valid);
            end
        end
    endtask

    task automatic test_spacing();
        do_reset();
        ch_data[47:32] = 16'hFFFB;
        en = 1'b1; ch_valid = 4'b0100;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (ch_ready !== ((k % 3 == 0) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL space_ready k=%0d got %b exp %b", k, ch_ready,
                         (k % 3 == 0) ? 4'b0100 : 4'b0000);
            end
            checks++;
            if (eng_valid !== (k >= 1 && (k - 1) % 3 == 0)) begin
                errors++;
                $display("FAIL space_ev k=%0d got %b exp %b", k, eng_valid, (k >= 1 && (k - 1) % 3 == 0));
            end
            checks++;
            if (out_valid !== (k >= 4 && (k - 4) % 3 == 0)) begin
                errors++;
                $display("FAIL space_ov k=%0d got %b exp %b", k, out_valid, (k >= 4 && (k - 4) % 3 == 0));
            end else if (out_valid && (out_data !== 16'd9 || out_ch !== 2'd2)) begin
                errors++;
                $display("FAIL space_out k=%0d got d=%0d ch=%0d exp 9 2", k, out_data, out_ch);
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] pat [3];
        pat[0] = 4'b1000; pat[1] = 4'b0001; pat[2] = 4'b0000;
        do_reset();
        en = 1'b1; ch_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (ch_ready !== 4'b0100) begin errors++; $display("FAIL fair_setup got %b exp 0100", ch_ready); end
        @(posedge clk);
        #1 ch_valid = 4'b1001;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (ch_ready !== pat[(k - 1) % 3]) begin
                errors++;
                $display("FAIL fair_ready k=%0d got %b exp %b", k, ch_ready, pat[(k - 1) % 3]);
            end
        end
    endtask

    task automatic test_drain();
        do_reset();
        en = 1'b1; ch_valid = 4'hF;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 en = 1'b0;
        for (int k = 2; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (ch_ready !== 4'b0000 || eng_clr !== 1'b0) begin
                errors++;
                $display("FAIL drain_quiet k=%0d got rdy=%b clr=%b exp 0000 0", k, ch_ready, eng_clr);
            end
            checks++;
            if (out_valid !== (k == 4 || k == 5) || (out_valid && out_ch !== 2'(k - 4))) begin
                errors++;
                $display("FAIL drain_out k=%0d got ov=%b ch=%0d exp %b %0d", k, out_valid, out_ch,
                         (k == 4 || k == 5), k - 4);
            end
            checks++;
            if (idle !== (k >= 7)) begin
                errors++;
                $display("FAIL drain_idle k=%0d got %b exp %b", k, idle, (k >= 7));
            end
        end
        @(posedge clk);
        #1 en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (eng_clr !== 1'b1 || idle !== 1'b0 || ch_ready !== 4'b0100) begin
            errors++;
            $display("FAIL drain_rerun got clr=%b idle=%b rdy=%b exp 1 0 0100", eng_clr, idle, ch_ready);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        en = 1'b1; ch_valid = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_out k=%0d got %b exp 0", k, out_valid);
            end
            if (k == 1) begin
                checks++;
                if (ch_ready !== 4'b0001 || eng_clr !== 1'b1) begin
                    errors++;
                    $display("FAIL midrst_first got rdy=%b clr=%b exp 0001 1", ch_ready, eng_clr);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        dv[0] = 16'd100; dv[1] = 16'd200; dv[2] = 16'd300; dv[3] = 16'd400;
        rst = 1'b1; en = 1'b0; ch_valid = 4'h0; ch_data = '0;
        test_reset();
        test_rotation();
        test_spacing();
        test_fairness();
        test_drain();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
